// File: rtl/signed_mult_ctrl_if.sv
// Bundle between the signed multiplier controller, its requester and the
// unsigned shift-add datapath. The controller uses the slave view; the
// surrounding environment (requester plus datapath) uses the master view.
interface signed_mult_ctrl_if #(
  parameter int WIDTH = 8
);
  // Request / response side
  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     result;

  // Datapath side
  logic [WIDTH-1:0]       dp_multiplier;
  logic [WIDTH-1:0]       dp_multiplicand;
  logic                   dp_load;
  logic                   dp_shift_en;
  logic                   dp_reg_en;
  logic                   dp_psel;
  logic [2*WIDTH-2:0]     dp_product;
  logic                   dp_zflag;

  modport master (
    output start, a, b, dp_product, dp_zflag,
    input  busy, done, result,
    input  dp_multiplier, dp_multiplicand,
    input  dp_load, dp_shift_en, dp_reg_en, dp_psel
  );

  modport slave (
    input  start, a, b, dp_product, dp_zflag,
    output busy, done, result,
    output dp_multiplier, dp_multiplicand,
    output dp_load, dp_shift_en, dp_reg_en, dp_psel
  );
endinterface

// File: rtl/signed_mult_ctrl.sv
// Sequencing controller for a shift-add unsigned multiplier datapath.
// Converts two signed operands to sign/magnitude, steers the smaller
// magnitude to the multiplier input (optional), runs the datapath until the
// shifted multiplier is exhausted, and re-applies the sign to the product.
module signed_mult_ctrl #(
  parameter int WIDTH   = 8,
  parameter bit SWAP_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  signed_mult_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   count;
  logic               sign;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               pick_a;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] result_q;
  logic               finish;
  logic               load;
  logic               shift_en;
  logic               reg_en;
  logic               psel;

  // Unsigned magnitudes; negating the most negative value wraps to 2^(WIDTH-1),
  // which is exactly the magnitude when read as unsigned.
  always_comb begin
    mag_a  = bus.a[WIDTH-1] ? (-bus.a) : bus.a;
    mag_b  = bus.b[WIDTH-1] ? (-bus.b) : bus.b;
    pick_a = !SWAP_EN || (mag_a < mag_b);
  end

  // RUN ends when the multiplier is exhausted; the counter bound is a
  // safety net should the datapath never raise zflag.
  assign finish = (state == RUN) && (bus.dp_zflag || (count == CNT_W'(WIDTH)));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    reg_en     = 1'b0;
    psel       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) state_next = LOAD;
      end
      LOAD: begin
        load       = 1'b1;
        reg_en     = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (finish) begin
          state_next = DONE;
        end else begin
          reg_en   = 1'b1;
          psel     = 1'b1;
          shift_en = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, step counter and signed result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      sign     <= 1'b0;
      mplier_q <= '0;
      mcand_q  <= '0;
      result_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sign     <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            mplier_q <= pick_a ? mag_a : mag_b;
            mcand_q  <= pick_a ? mag_b : mag_a;
          end
        end
        LOAD: begin
          count <= '0;
        end
        RUN: begin
          if (finish) begin
            result_q <= sign ? -{1'b0, bus.dp_product} : {1'b0, bus.dp_product};
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy            = (state != IDLE);
  assign bus.done            = (state == DONE);
  assign bus.result          = result_q;
  assign bus.dp_multiplier   = mplier_q;
  assign bus.dp_multiplicand = mcand_q;
  assign bus.dp_load         = load;
  assign bus.dp_shift_en     = shift_en;
  assign bus.dp_reg_en       = reg_en;
  assign bus.dp_psel         = psel;

endmodule

// File: tb/tb_signed_mult_ctrl.sv
// Self-checking bench for signed_mult_ctrl. A behavioural shift-add datapath
// closes the loop; expected results, latencies and step counts come from
// plain signed arithmetic on the operands.
module tb_signed_mult_ctrl;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  signed_mult_ctrl_if #(.WIDTH(WIDTH)) bus ();

  signed_mult_ctrl #(
    .WIDTH   (WIDTH),
    .SWAP_EN (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural unsigned datapath; starts with garbage so LOAD must clear it.
  logic [WIDTH-1:0]   m_mplier = 8'h5A;
  logic [2*WIDTH-2:0] m_mcand  = 15'h1234;
  logic [2*WIDTH-2:0] m_prod   = 15'h2AAA;

  always @(posedge clk) begin
    if (bus.dp_load) begin
      m_mplier <= bus.dp_multiplier;
      m_mcand  <= {{(WIDTH-1){1'b0}}, bus.dp_multiplicand};
    end else if (bus.dp_shift_en) begin
      m_mplier <= m_mplier >> 1;
      m_mcand  <= m_mcand << 1;
    end
    if (bus.dp_reg_en) begin
      m_prod <= bus.dp_psel ? (m_prod + (m_mplier[0] ? m_mcand : '0)) : '0;
    end
  end

  assign bus.dp_product = m_prod;
  assign bus.dp_zflag   = (m_mplier == '0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ctrl_bits();
    return {bus.dp_load, bus.dp_shift_en, bus.dp_reg_en, bus.dp_psel};
  endfunction

  // One multiplication. Latency is counted from the cycle in which start is
  // presented (cycle 0) to the cycle in which done is high. disturb > 0
  // pulses start with other operands in that cycle; extra_start_in_done
  // presents a start during the DONE cycle, which must be ignored.
  task automatic do_op(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in,
                       input int disturb, input bit extra_start_in_done);
    int sa, sb, ma, mb, exp_mplier, exp_mcand, k, v, cyc, acc;
    logic [2*WIDTH-1:0] exp_res;
    sa = int'($signed(a_in));
    sb = int'($signed(b_in));
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    exp_mplier = (ma < mb) ? ma : mb;
    exp_mcand  = (ma < mb) ? mb : ma;
    exp_res    = 16'(sa * sb);
    k = 0;
    v = exp_mplier;
    while (v > 0) begin
      v = v >> 1;
      k++;
    end

    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_ctrl", 32'(ctrl_bits()), 32'd0);
    bus.start = 1'b1;
    bus.a     = a_in;
    bus.b     = b_in;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    acc = 0;
    check("load_ctrl", 32'(ctrl_bits()), 32'b1010);
    check("mplier", 32'(bus.dp_multiplier), 32'(exp_mplier));
    check("mcand", 32'(bus.dp_multiplicand), 32'(exp_mcand));
    while (!bus.done && cyc < 40) begin
      if (bus.dp_reg_en && bus.dp_psel) acc++;
      bus.a     = WIDTH'($urandom);
      bus.b     = WIDTH'($urandom);
      bus.start = (cyc == disturb);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check("done_seen", 32'(bus.done), 32'd1);
    check("latency", 32'(cyc), 32'(k + 3));
    check("acc_steps", 32'(acc), 32'(k));
    check("result", 32'(bus.result), 32'(exp_res));
    check("done_ctrl", 32'(ctrl_bits()), 32'd0);
    check("mplier_held", 32'(bus.dp_multiplier), 32'(exp_mplier));
    if (extra_start_in_done) begin
      bus.start = 1'b1;
      bus.a     = WIDTH'($urandom);
      bus.b     = WIDTH'($urandom);
      @(negedge clk);
      bus.start = 1'b0;
      check("done_start_ignored", 32'(bus.busy), 32'd0);
      check("done_pulse_single", 32'(bus.done), 32'd0);
      check("result_held", 32'(bus.result), 32'(exp_res));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_ctrl", 32'(ctrl_bits()), 32'd0);
    check("rst_mplier", 32'(bus.dp_multiplier), 32'd0);
    check("rst_mcand", 32'(bus.dp_multiplicand), 32'd0);
    rst = 1'b0;

    // Directed cases, back to back.
    do_op(8'd5, 8'd3, 0, 1'b0);
    do_op(8'hF9, 8'd9, 0, 1'b0);      // -7 * 9
    do_op(8'h80, 8'h80, 0, 1'b0);     // -128 * -128
    do_op(8'd127, 8'h80, 0, 1'b0);    // 127 * -128
    do_op(8'd0, 8'hB3, 0, 1'b0);      // 0 * -77
    do_op(8'd100, 8'hFD, 3, 1'b0);    // start pulsed again while running
    do_op(8'hC8, 8'd45, 0, 1'b1);     // start presented in DONE cycle

    // Randomized operands with a bias towards boundary values.
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 8'h80;
        1: rb = 8'h80;
        2: ra = 8'h00;
        3: rb = 8'h7F;
        4: rb = ra;
        default: ;
      endcase
      do_op(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 6)) : 0,
            ($urandom_range(0, 4) == 0));
    end

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd50;
    bus.b     = 8'hC4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_ctrl", 32'(ctrl_bits()), 32'd0);
    rst = 1'b0;
    do_op(8'd2, 8'hFE, 0, 1'b0);      // 2 * -2 with stale datapath product

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
